// File: rtl/instr_prefetch_queue_pkg.sv
// Shared constants and types for the instruction prefetch queue.
// Holds the machine word width, the fetch increment and the default configuration.
package instr_prefetch_queue_pkg;

   localparam int XLEN          = 32;
   localparam int INST_BYTES    = 4;
   localparam int DEFAULT_DEPTH = 4;

   typedef logic [XLEN-1:0] word_t;

   localparam word_t DEFAULT_RESET_PC = 32'h0000_0000;
   localparam word_t INST_INC         = word_t'(INST_BYTES);

   // One queue slot: the fetched word together with the address it came from.
   typedef struct packed {
      word_t pc;
      word_t data;
   } fifo_entry_t;

   function automatic word_t align_pc(input word_t pc);
      return {pc[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/instr_prefetch_queue_sync_fifo.sv
// Circular storage for fetched instructions: DEPTH slots of {pc, data}.
// Wrap-around pointers; flush empties the queue in one cycle.
module sync_fifo
   import instr_prefetch_queue_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       push_i,
   input  fifo_entry_t                push_entry_i,
   input  logic                       pop_i,
   input  logic                       flush_i,
   output logic [$clog2(DEPTH+1)-1:0] count_o,
   output fifo_entry_t                head_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   fifo_entry_t      mem_q [DEPTH];

   logic do_push;
   logic do_pop;

   assign do_pop  = pop_i && (count_q != '0);
   assign do_push = push_i && !flush_i && ((count_q != FULL_CNT) || do_pop);

   // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         // Power-of-two depth lets the pointers wrap by plain overflow.
         if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: the storage array is not reset; slots are only read once count says they hold data.
   always_ff @(posedge clock) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_entry_i;
      end
   end

   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: issues sequential fetches, buffers returned words in order,
// and discards responses that belong to fetches made before a redirect.
module instr_prefetch_queue
   import instr_prefetch_queue_pkg::*;
#(
   parameter int    DEPTH    = DEFAULT_DEPTH,
   parameter word_t RESET_PC = DEFAULT_RESET_PC
) (
   input  logic            clock,
   input  logic            reset,
   output logic            imem_req_valid,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_req_ready,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            inst_valid,
   output logic [XLEN-1:0] inst_data,
   output logic [XLEN-1:0] inst_pc,
   input  logic            inst_ready
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W:0] DEPTH_EXT = (CNT_W + 1)'(DEPTH);

   word_t            fetch_pc_q, fetch_pc_d;
   word_t            rsp_pc_q, rsp_pc_d;
   logic [CNT_W-1:0] inflight_q, inflight_d;
   logic [CNT_W-1:0] drop_q, drop_d;

   logic [CNT_W-1:0] count;
   logic [CNT_W:0]   occupancy;
   fifo_entry_t      head;
   fifo_entry_t      push_entry;
   logic             accept;
   logic             rsp_dec;
   logic             push;
   logic             pop;

   // Slots already filled plus slots reserved by outstanding fetches; never exceeds DEPTH.
   assign occupancy      = {1'b0, count} + {1'b0, inflight_q};
   assign imem_req_valid = !reset && !redirect_valid && (occupancy < DEPTH_EXT);
   assign imem_req_addr  = fetch_pc_q;
   assign accept         = imem_req_valid && imem_req_ready;

   assign rsp_dec    = imem_rsp_valid && (inflight_q != '0);
   assign push       = rsp_dec && (drop_q == '0) && !redirect_valid;
   assign push_entry = '{pc: rsp_pc_q, data: imem_rsp_data};

   assign inst_valid = !reset && (count != '0);
   assign pop        = inst_valid && inst_ready;
   assign inst_data  = head.data;
   assign inst_pc    = head.pc;

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      rsp_pc_d   = rsp_pc_q;
      drop_d     = drop_q;
      inflight_d = inflight_q + CNT_W'(accept) - CNT_W'(rsp_dec);
      if (redirect_valid) begin
         fetch_pc_d = align_pc(redirect_pc);
         rsp_pc_d   = align_pc(redirect_pc);
         // Every fetch still outstanding after this cycle predates the redirect.
         drop_d     = inflight_d;
      end else begin
         if (accept) begin
            fetch_pc_d = fetch_pc_q + INST_INC;
         end
         if (rsp_dec) begin
            if (drop_q != '0) begin
               drop_d = drop_q - CNT_W'(1);
            end else begin
               rsp_pc_d = rsp_pc_q + INST_INC;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         fetch_pc_q <= RESET_PC;
         rsp_pc_q   <= RESET_PC;
         inflight_q <= '0;
         drop_q     <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         rsp_pc_q   <= rsp_pc_d;
         inflight_q <= inflight_d;
         drop_q     <= drop_d;
      end
   end

   sync_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock        (clock),
      .reset        (reset),
      .push_i       (push),
      .push_entry_i (push_entry),
      .pop_i        (pop),
      .flush_i      (redirect_valid),
      .count_o      (count),
      .head_o       (head)
   );

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Self-checking bench for instr_prefetch_queue: directed vector tables, corner-case
// sequences and a long randomized run against an in-order stream model.
module tb_instr_prefetch_queue;
   import instr_prefetch_queue_pkg::*;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clock;
   logic        reset;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic        inst_ready;

   instr_prefetch_queue #(
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .imem_req_valid (imem_req_valid),
      .imem_req_addr  (imem_req_addr),
      .imem_req_ready (imem_req_ready),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc),
      .inst_ready     (inst_ready)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;

   typedef struct {
      logic        rst;
      logic        req_rdy;
      logic        inst_rdy;
      logic        e_req_v;
      logic [31:0] e_req_addr;
      logic        e_inst_v;
      logic [31:0] e_inst_pc;
   } vec_t;

   mreq_t       mq[$];
   vec_t        vecs[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          lat_lo = 1;
   int          lat_hi = 1;
   int          last_due = 0;
   int          pops = 0;
   bit          wrapped = 0;
   logic [31:0] model_fetch, exp_pc, last_pop_pc;
   logic        prev_req_v = 1'b0;
   logic        prev_acc = 1'b0;
   logic [31:0] prev_addr = '0;
   logic        s_req_v, s_inst_v;
   logic [31:0] s_req_addr, s_inst_pc, s_inst_data;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   function automatic vec_t mk(input logic rst, input logic req_rdy, input logic inst_rdy,
                               input logic e_req_v, input logic [31:0] e_req_addr,
                               input logic e_inst_v, input logic [31:0] e_inst_pc);
      vec_t v;
      v.rst = rst; v.req_rdy = req_rdy; v.inst_rdy = inst_rdy;
      v.e_req_v = e_req_v; v.e_req_addr = e_req_addr;
      v.e_inst_v = e_inst_v; v.e_inst_pc = e_inst_pc;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock cycle: drive inputs, play the memory, sample outputs, check against the stream model.
   task automatic step(input logic rst, input logic redir, input logic [31:0] rpc,
                       input logic req_rdy, input logic inst_rdy);
      int occ;
      int d;
      @(negedge clock);
      reset          = rst;
      redirect_valid = redir;
      redirect_pc    = rpc;
      imem_req_ready = req_rdy;
      inst_ready     = inst_rdy;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      if (rst) begin
         mq.delete();
         last_due = 0;
      end
      occ = mq.size();
      if (!rst && mq.size() > 0 && mq[0].due <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_word(mq[0].addr);
         void'(mq.pop_front());
      end
      #1;
      s_req_v     = imem_req_valid;
      s_req_addr  = imem_req_addr;
      s_inst_v    = inst_valid;
      s_inst_pc   = inst_pc;
      s_inst_data = inst_data;
      if (rst) begin
         check("reset_req_valid", 32'(s_req_v), 32'd0);
         check("reset_inst_valid", 32'(s_inst_v), 32'd0);
         model_fetch = RESET_PC;
         exp_pc      = RESET_PC;
         prev_req_v  = 1'b0;
         prev_acc    = 1'b0;
      end else begin
         if (redir) check("redirect_blocks_req", 32'(s_req_v), 32'd0);
         if (prev_req_v && !prev_acc && !redir) begin
            check("req_held_valid", 32'(s_req_v), 32'd1);
            check("req_held_addr", s_req_addr, prev_addr);
         end
         if (s_req_v) begin
            check("req_addr", s_req_addr, model_fetch);
            check("req_room", 32'(occ < DEPTH), 32'd1);
         end
         if (!redir && !s_inst_v && occ == 0) check("req_not_starved", 32'(s_req_v), 32'd1);
         if (s_inst_v && inst_rdy) begin
            check("pop_pc", s_inst_pc, exp_pc);
            check("pop_data", s_inst_data, mem_word(exp_pc));
            if (exp_pc == 32'h0000_0000 && last_pop_pc == 32'hFFFF_FFFC && pops > 0) wrapped = 1;
            last_pop_pc = exp_pc;
            exp_pc      = exp_pc + 32'd4;
            pops++;
         end
         if (s_req_v && req_rdy) begin
            d = cyc + int'($urandom_range(lat_hi, lat_lo));
            if (d < last_due) d = last_due;
            last_due = d;
            mq.push_back('{addr: s_req_addr, due: d});
            model_fetch = model_fetch + 32'd4;
         end
         if (redir) begin
            model_fetch = rpc & ~32'd3;
            exp_pc      = rpc & ~32'd3;
         end
         prev_req_v = s_req_v;
         prev_acc   = s_req_v && req_rdy;
         prev_addr  = s_req_addr;
      end
      cyc++;
   endtask

   // Waits (bounded) for the head to become valid without consuming it.
   task automatic wait_head(input string name, input logic [31:0] want_pc);
      bit found = 0;
      for (int i = 0; i < 40; i++) begin
         step(1'b0, 1'b0, '0, 1'b1, 1'b0);
         if (s_inst_v) begin
            found = 1;
            break;
         end
      end
      check({name, "_head_seen"}, 32'(found), 32'd1);
      if (found) begin
         check({name, "_head_pc"}, s_inst_pc, want_pc);
         check({name, "_head_data"}, s_inst_data, mem_word(want_pc));
      end
   endtask

   initial begin
      reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0; inst_ready = 1'b0;
      model_fetch = RESET_PC; exp_pc = RESET_PC; last_pop_pc = '0;

      // Streaming with 1-cycle memory and a consumer that is always ready.
      vecs.push_back(mk(1, 1, 1, 0, '0, 0, '0));
      vecs.push_back(mk(1, 1, 1, 0, '0, 0, '0));
      for (int k = 0; k < 8; k++)
         vecs.push_back(mk(0, 1, 1, 1, 32'(4 * k), k >= 2, 32'(4 * (k - 2))));
      // Consumer stalls for 10 cycles: four fetches fill the queue, then draining resumes fetching.
      vecs.push_back(mk(1, 1, 0, 0, '0, 0, '0));
      vecs.push_back(mk(1, 1, 0, 0, '0, 0, '0));
      for (int k = 0; k < 10; k++)
         vecs.push_back(mk(0, 1, 0, k < 4, 32'(4 * k), k >= 2, 32'h0));
      vecs.push_back(mk(0, 1, 1, 0, '0, 1, 32'h00));
      vecs.push_back(mk(0, 1, 1, 1, 32'h10, 1, 32'h04));
      vecs.push_back(mk(0, 1, 1, 1, 32'h14, 1, 32'h08));
      vecs.push_back(mk(0, 1, 1, 1, 32'h18, 1, 32'h0C));
      vecs.push_back(mk(0, 1, 1, 1, 32'h1C, 1, 32'h10));

      lat_lo = 1; lat_hi = 1;
      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].rst, 1'b0, '0, vecs[i].req_rdy, vecs[i].inst_rdy);
         check($sformatf("vec%0d_req_valid", i), 32'(s_req_v), 32'(vecs[i].e_req_v));
         if (vecs[i].e_req_v)
            check($sformatf("vec%0d_req_addr", i), s_req_addr, vecs[i].e_req_addr);
         check($sformatf("vec%0d_inst_valid", i), 32'(s_inst_v), 32'(vecs[i].e_inst_v));
         if (vecs[i].e_inst_v) begin
            check($sformatf("vec%0d_inst_pc", i), s_inst_pc, vecs[i].e_inst_pc);
            check($sformatf("vec%0d_inst_data", i), s_inst_data, mem_word(vecs[i].e_inst_pc));
         end
      end

      // 3-cycle memory, redirect to 0x103 while two fetches are outstanding.
      lat_lo = 3; lat_hi = 3;
      step(1, 0, '0, 1, 1); step(1, 0, '0, 1, 1);
      step(0, 0, '0, 1, 1); step(0, 0, '0, 1, 1);
      step(0, 1, 32'h0000_0103, 1, 1);
      wait_head("redir_drop", 32'h0000_0100);

      // Redirect, response and pop all in the same cycle.
      lat_lo = 1; lat_hi = 1;
      step(1, 0, '0, 1, 1); step(1, 0, '0, 1, 1);
      step(0, 0, '0, 1, 1); step(0, 0, '0, 1, 1); step(0, 0, '0, 1, 1);
      step(0, 1, 32'h0000_0200, 1, 1);
      check("redir_rsp_pop_valid", 32'(s_inst_v), 32'd1);
      step(0, 0, '0, 1, 1);
      check("redir_rsp_pop_empty", 32'(s_inst_v), 32'd0);
      wait_head("redir_rsp_pop", 32'h0000_0200);

      // Reset with the queue half full and two fetches outstanding.
      lat_lo = 3; lat_hi = 3;
      step(1, 0, '0, 1, 0); step(1, 0, '0, 1, 0);
      for (int k = 0; k < 5; k++) step(0, 0, '0, 1, 0);
      check("midreset_pre_valid", 32'(s_inst_v), 32'd1);
      step(1, 0, '0, 1, 0); step(1, 0, '0, 1, 0);
      wait_head("midreset", RESET_PC);

      // Long randomized run starting just below the top of the address space.
      lat_lo = 1; lat_hi = 4;
      step(1, 0, '0, 1, 1); step(1, 0, '0, 1, 1);
      step(0, 1, 32'hFFFF_FFFB, 1, 1);
      pops = 0;
      wrapped = 0;
      for (int n = 0; n < 10000; n++) begin
         logic        rd;
         logic [31:0] rp;
         rd = ($urandom_range(199, 0) == 0);
         rp = 32'hFFFF_FF00 | 32'($urandom_range(255, 0));
         step(1'b0, rd, rp, ($urandom_range(3, 0) != 0), ($urandom_range(2, 0) != 0));
      end
      check("random_wrapped_to_zero", 32'(wrapped), 32'd1);
      check("random_throughput", 32'(pops > 1000), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
